pc_sequencer: RTL and testbench

- Parametrised successor to the fetch PC controller in the Tomasulo core.
- Holds the next-fetch address and issues one instruction address per cycle to decode when all tracked reservation-station, load/store and ROB channels report empty.
- Applies ROB flush redirects and taken-branch redirects; redirects are never lost, even when they arrive during a stall.
- Adds a startup hold-off counter, a halt mode and a saturating stall counter.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/startup_counter.sv | 27 ++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and default datapath widths/opcodes
// used by the fetch sequencer, decode and ROB.
package cpu_pkg;

  localparam int unsigned AddrWDefault    = 32;
  localparam int unsigned OpWDefault      = 6;
  localparam logic [5:0]  BranchOpDefault = 6'b001000;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } seq_state_e;

endpackage

// File: rtl/startup_counter.sv
// Post-reset hold-off down-counter; done rises once CYCLES enabled clocks have elapsed
// and stays high until the next reset.
module startup_counter #(
  parameter int unsigned CYCLES = 200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic done
);

  localparam int unsigned    CntW    = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(CYCLES);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CntInit;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: issues one address per cycle to decode when all tracked units are
// empty, with flush/branch redirects that survive stalls, startup hold-off and halt.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W         = AddrWDefault,
  parameter int unsigned       NUM_CH         = 5,
  parameter int unsigned       INCR           = 1,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned       STARTUP_CYCLES = 200,
  parameter int unsigned       OP_W           = OpWDefault,
  parameter logic [OP_W-1:0]   BRANCH_OP      = OP_W'(BranchOpDefault),
  parameter int unsigned       STALL_CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_CH-1:0]      unit_empty,
  input  logic [OP_W-1:0]        operator_type,
  input  logic                   jump,
  input  logic [ADDR_W-1:0]      jump_pc,
  input  logic                   pc_change,
  input  logic [ADDR_W-1:0]      change_data,
  input  logic                   halt,
  output logic                   available,
  output logic [ADDR_W-1:0]      pc,
  output logic                   decode_pulse,
  output logic                   running,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [ADDR_W-1:0] IncrVal = ADDR_W'(INCR);

  seq_state_e             state_q;
  logic [ADDR_W-1:0]      pc_q;
  logic [ADDR_W-1:0]      next_pc_q;
  logic                   available_q;
  logic                   decode_q;
  logic                   running_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic                   all_empty;
  logic                   take_jump;
  logic                   issue;
  logic                   stall_inc;
  logic                   cnt_done;
  logic [ADDR_W-1:0]      fetch_addr;

  startup_counter #(
    .CYCLES (STARTUP_CYCLES)
  ) u_startup_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state_q == StWait),
    .done    (cnt_done)
  );

  assign all_empty = &unit_empty;

  // Flush wins over branch; branches are meaningless before the core has started.
  always_comb begin
    take_jump  = jump && (operator_type == BRANCH_OP) && (state_q != StWait);
    fetch_addr = next_pc_q;
    if (pc_change) begin
      fetch_addr = change_data;
    end else if (take_jump) begin
      fetch_addr = jump_pc;
    end
  end

  always_comb begin
    issue     = (state_q == StRun) && !halt && all_empty;
    stall_inc = (state_q == StRun) && !halt && !issue && !(&stall_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWait;
      pc_q        <= RESET_PC;
      next_pc_q   <= RESET_PC;
      available_q <= 1'b0;
      decode_q    <= 1'b0;
      running_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      available_q <= all_empty;
      decode_q    <= issue;

      // Without an issue the selected address is parked so a redirect is never lost.
      if (issue) begin
        pc_q      <= fetch_addr;
        next_pc_q <= fetch_addr + IncrVal;
      end else begin
        next_pc_q <= fetch_addr;
      end

      if (stall_inc) begin
        stall_q <= stall_q + STALL_CNT_W'(1);
      end

      case (state_q)
        StWait: begin
          if (cnt_done) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (halt) begin
            state_q <= StHalt;
          end
        end
        StHalt: begin
          if (!halt) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign available    = available_q;
  assign pc           = pc_q;
  assign decode_pulse = decode_q;
  assign running      = running_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a 3-cycle startup hold-off.
module tb_pc_sequencer;

  localparam logic [5:0] BrOp = 6'b001000;

  logic        clock;
  logic        reset_n;
  logic [4:0]  unit_empty;
  logic [5:0]  operator_type;
  logic        jump;
  logic [31:0] jump_pc;
  logic        pc_change;
  logic [31:0] change_data;
  logic        halt;
  logic        available;
  logic [31:0] pc;
  logic        decode_pulse;
  logic        running;
  logic [15:0] stall_count;

  int checks = 0;
  int fails  = 0;

  pc_sequencer #(
    .ADDR_W         (32),
    .NUM_CH         (5),
    .INCR           (1),
    .RESET_PC       (32'h0),
    .STARTUP_CYCLES (3),
    .OP_W           (6),
    .BRANCH_OP      (BrOp),
    .STALL_CNT_W    (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .unit_empty    (unit_empty),
    .operator_type (operator_type),
    .jump          (jump),
    .jump_pc       (jump_pc),
    .pc_change     (pc_change),
    .change_data   (change_data),
    .halt          (halt),
    .available     (available),
    .pc            (pc),
    .decode_pulse  (decode_pulse),
    .running       (running),
    .stall_count   (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (pc !== 32'h0 || decode_pulse !== 1'b0 || running !== 1'b0 || available !== 1'b0 ||
        stall_count !== 16'h0) begin
      $display("FAIL %s: pc=%h pulse=%b run=%b avail=%b stall=%0d, required 0/0/0/0/0",
               tag, pc, decode_pulse, running, available, stall_count);
      fails++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; unit_empty = '1; operator_type = '0; jump = 1'b0; jump_pc = '0;
    pc_change = 1'b0; change_data = '0; halt = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    reset_n = 1'b1;
  endtask

  task automatic test_startup();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (decode_pulse !== 1'b0) begin
        $display("FAIL startup_hold[%0d]: pulse=%b required 0", i, decode_pulse); fails++;
      end
    end
    checks++;
    if (running !== 1'b1 || available !== 1'b1) begin
      $display("FAIL startup_running: run=%b avail=%b required 1/1", running, available); fails++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'(i) || decode_pulse !== 1'b1) begin
        $display("FAIL startup_issue[%0d]: pc=%h pulse=%b required %h/1", i, pc, decode_pulse, i);
        fails++;
      end
    end
  endtask

  task automatic test_stall();
    tick(); tick(); tick();
    checks++;
    if (pc !== 32'h5) begin
      $display("FAIL stall_pre: pc=%h required 5", pc); fails++;
    end
    unit_empty = 5'b11011;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== 32'h5 || decode_pulse !== 1'b0 || available !== 1'b0) begin
        $display("FAIL stall_hold[%0d]: pc=%h pulse=%b avail=%b required 5/0/0",
                 i, pc, decode_pulse, available);
        fails++;
      end
    end
    checks++;
    if (stall_count !== 16'd4) begin
      $display("FAIL stall_count: got %0d required 4", stall_count); fails++;
    end
    unit_empty = '1;
    tick();
    checks++;
    if (pc !== 32'h6 || decode_pulse !== 1'b1 || stall_count !== 16'd4) begin
      $display("FAIL stall_resume: pc=%h pulse=%b stall=%0d required 6/1/4",
               pc, decode_pulse, stall_count);
      fails++;
    end
  endtask

  task automatic test_branch();
    operator_type = BrOp; jump = 1'b1; jump_pc = 32'h40;
    tick();
    checks++;
    if (pc !== 32'h40 || decode_pulse !== 1'b1) begin
      $display("FAIL branch_taken: pc=%h pulse=%b required 40/1", pc, decode_pulse); fails++;
    end
    jump = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h41) begin
      $display("FAIL branch_follow: pc=%h required 41", pc); fails++;
    end
    operator_type = 6'h00; jump = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h42) begin
      $display("FAIL branch_wrong_op: pc=%h required 42", pc); fails++;
    end
    jump = 1'b0;
  endtask

  task automatic test_priority();
    pc_change = 1'b1; change_data = 32'h100;
    operator_type = BrOp; jump = 1'b1; jump_pc = 32'h40;
    tick();
    checks++;
    if (pc !== 32'h100) begin
      $display("FAIL priority: pc=%h required 100", pc); fails++;
    end
    pc_change = 1'b0; jump = 1'b0; operator_type = '0;
    tick();
    checks++;
    if (pc !== 32'h101) begin
      $display("FAIL priority_follow: pc=%h required 101", pc); fails++;
    end
  endtask

  task automatic test_pending_redirect();
    unit_empty = 5'b11110; pc_change = 1'b1; change_data = 32'h80;
    tick();
    pc_change = 1'b0;
    tick(); tick();
    checks++;
    if (pc !== 32'h101 || decode_pulse !== 1'b0) begin
      $display("FAIL pending_hold: pc=%h pulse=%b required 101/0", pc, decode_pulse); fails++;
    end
    unit_empty = '1;
    tick();
    checks++;
    if (pc !== 32'h80 || decode_pulse !== 1'b1) begin
      $display("FAIL pending_issue: pc=%h pulse=%b required 80/1", pc, decode_pulse); fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h81 || decode_pulse !== 1'b1 || stall_count !== 16'd7) begin
      $display("FAIL back_to_back: pc=%h pulse=%b stall=%0d required 81/1/7",
               pc, decode_pulse, stall_count);
      fails++;
    end
  endtask

  task automatic test_overwrite();
    unit_empty = 5'b01111; pc_change = 1'b1; change_data = 32'h200;
    tick();
    change_data = 32'h300;
    tick();
    pc_change = 1'b0; unit_empty = '1;
    tick();
    checks++;
    if (pc !== 32'h300 || stall_count !== 16'd9) begin
      $display("FAIL overwrite: pc=%h stall=%0d required 300/9", pc, stall_count); fails++;
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (decode_pulse !== 1'b0 || pc !== 32'h300 || stall_count !== 16'd9) begin
        $display("FAIL halt_hold[%0d]: pulse=%b pc=%h stall=%0d required 0/300/9",
                 i, decode_pulse, pc, stall_count);
        fails++;
      end
    end
    halt = 1'b0;
    tick();
    checks++;
    if (decode_pulse !== 1'b0 || stall_count !== 16'd9) begin
      $display("FAIL halt_exit: pulse=%b stall=%0d required 0/9", decode_pulse, stall_count);
      fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h301 || decode_pulse !== 1'b1) begin
      $display("FAIL halt_resume: pc=%h pulse=%b required 301/1", pc, decode_pulse); fails++;
    end
  endtask

  task automatic test_wrap();
    pc_change = 1'b1; change_data = 32'hFFFF_FFFF;
    tick();
    pc_change = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_top: pc=%h required ffffffff", pc); fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h0 || decode_pulse !== 1'b1) begin
      $display("FAIL wrap_zero: pc=%h pulse=%b required 0/1", pc, decode_pulse); fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h1) begin
      $display("FAIL wrap_next: pc=%h required 1", pc); fails++;
    end
  endtask

  task automatic test_async_reset();
    unit_empty = 5'b10111; pc_change = 1'b1; change_data = 32'h500;
    tick();
    pc_change = 1'b0; unit_empty = '1;
    reset_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (decode_pulse !== 1'b0 || running !== 1'b1) begin
      $display("FAIL reset_restart: pulse=%b run=%b required 0/1", decode_pulse, running);
      fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h0 || decode_pulse !== 1'b1) begin
      $display("FAIL reset_discard: pc=%h pulse=%b required 0/1", pc, decode_pulse); fails++;
    end
  endtask

  task automatic test_wait_redirect();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    pc_change = 1'b1; change_data = 32'h20;
    tick();
    pc_change = 1'b0; operator_type = BrOp; jump = 1'b1; jump_pc = 32'h60;
    tick();
    jump = 1'b0; operator_type = '0;
    tick(); tick();
    tick();
    checks++;
    if (pc !== 32'h20 || decode_pulse !== 1'b1) begin
      $display("FAIL wait_redirect: pc=%h pulse=%b required 20/1", pc, decode_pulse); fails++;
    end
    tick();
    checks++;
    if (pc !== 32'h21) begin
      $display("FAIL wait_redirect_next: pc=%h required 21", pc); fails++;
    end
  endtask

  task automatic test_saturate();
    unit_empty = 5'b11101;
    repeat (65540) tick();
    checks++;
    if (stall_count !== 16'hFFFF || pc !== 32'h21) begin
      $display("FAIL stall_saturate: stall=%h pc=%h required ffff/21", stall_count, pc);
      fails++;
    end
    unit_empty = '1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_branch();
    test_priority();
    test_pending_redirect();
    test_overwrite();
    test_halt();
    test_wrap();
    test_async_reset();
    test_wait_redirect();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
